// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: PLL reset/lock sequencer producing pll_rst, sys_rst_n and ready
module pll_lock_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLLRST_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int STABLE_CYCLES  = 1024,
    parameter int HOLD_CYCLES    = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       locked_async,
    input  logic       clr_cnt,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic [7:0] relock_cnt
);
    localparam int M1   = PLLRST_CYCLES > TIMEOUT_CYCLES ? PLLRST_CYCLES : TIMEOUT_CYCLES;
    localparam int M2   = STABLE_CYCLES > HOLD_CYCLES ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int MAXP = M1 > M2 ? M1 : M2;
    localparam int CW   = MAXP > 1 ? $clog2(MAXP) : 1;
    localparam logic [CW-1:0] P_LAST = CW'(PLLRST_CYCLES - 1);
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] S_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] H_LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {PLLRST, WAIT_LOCK, STABLE, HOLD, RUN} state_t;

    state_t                 state, nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   lk;
    logic                   inc;

    assign lk  = sync[SYNC_STAGES-1];
    assign inc = (state == RUN) && !lk;

    // bring the PLL lock indicator into the clk domain
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) sync <= '0;
        else       sync <= {sync[SYNC_STAGES-2:0], locked_async};
    end

    // next state; the shared counter restarts on every state change and idles in RUN
    always_comb begin
        nxt = state;
        case (state)
            PLLRST:    nxt = cnt == P_LAST ? WAIT_LOCK : PLLRST;
            WAIT_LOCK: nxt = lk ? STABLE : (cnt == T_LAST ? PLLRST : WAIT_LOCK);
            STABLE:    nxt = !lk ? WAIT_LOCK : (cnt == S_LAST ? HOLD : STABLE);
            HOLD:      nxt = !lk ? WAIT_LOCK : (cnt == H_LAST ? RUN : HOLD);
            RUN:       nxt = lk ? RUN : WAIT_LOCK;
            default:   nxt = PLLRST;
        endcase
        cnt_nxt = (nxt != state || state == RUN) ? '0 : cnt + 1'b1;
    end

    // state, counter and registered outputs derived from the next state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= PLLRST;
            cnt        <= '0;
            pll_rst    <= 1'b1;
            sys_rst_n  <= 1'b0;
            ready      <= 1'b0;
            relock_cnt <= '0;
        end else begin
            state      <= nxt;
            cnt        <= cnt_nxt;
            pll_rst    <= nxt == PLLRST;
            sys_rst_n  <= nxt == RUN;
            ready      <= nxt == RUN;
            relock_cnt <= clr_cnt ? 8'd0 : (inc && relock_cnt != 8'hff ? relock_cnt + 8'd1 : relock_cnt);
        end
    end
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed checks of the PLL lock sequencer
module tb_pll_lock_sequencer;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       locked_async = 1'b0;
    logic       clr_cnt = 1'b0;
    logic       pll_rst, sys_rst_n, ready;
    logic [7:0] relock_cnt;
    int         n_assert = 0;
    int         n_fail = 0;

    pll_lock_sequencer #(
        .SYNC_STAGES(2), .PLLRST_CYCLES(4), .TIMEOUT_CYCLES(32),
        .STABLE_CYCLES(8), .HOLD_CYCLES(4)
    ) dut (
        .clk(clk), .rstn(rstn), .locked_async(locked_async), .clr_cnt(clr_cnt),
        .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .ready(ready), .relock_cnt(relock_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic lose_lock();
        locked_async = 1'b0;
        tick(3);
        locked_async = 1'b1;
    endtask

    initial begin
        locked_async = 1'b1;
        tick(1);
        chk("rst_pll_rst", {7'd0, pll_rst}, 8'd1);
        chk("rst_sys_rst_n", {7'd0, sys_rst_n}, 8'd0);
        chk("rst_ready", {7'd0, ready}, 8'd0);
        chk("rst_relock", relock_cnt, 8'd0);

        do_reset();
        tick(3);
        chk("clean_pll_rst_e3", {7'd0, pll_rst}, 8'd1);
        tick(1);
        chk("clean_pll_rst_e4", {7'd0, pll_rst}, 8'd0);
        tick(12);
        chk("clean_ready_e16", {7'd0, ready}, 8'd0);
        tick(1);
        chk("clean_ready_e17", {7'd0, ready}, 8'd1);
        chk("clean_sys_rst_n_e17", {7'd0, sys_rst_n}, 8'd1);
        chk("clean_relock", relock_cnt, 8'd0);

        locked_async = 1'b0;
        tick(2);
        chk("loss_ready_r2", {7'd0, ready}, 8'd1);
        tick(1);
        locked_async = 1'b1;
        chk("loss_ready_r3", {7'd0, ready}, 8'd0);
        chk("loss_sys_rst_n_r3", {7'd0, sys_rst_n}, 8'd0);
        chk("loss_relock", relock_cnt, 8'd1);
        tick(14);
        chk("relock_ready_r17", {7'd0, ready}, 8'd0);
        tick(1);
        chk("relock_ready_r18", {7'd0, ready}, 8'd1);

        for (int i = 2; i <= 260; i++) begin
            lose_lock();
            tick(15);
            if (i == 255) chk("sat_reach_255", relock_cnt, 8'd255);
        end
        chk("sat_relock", relock_cnt, 8'd255);
        chk("sat_ready", {7'd0, ready}, 8'd1);

        locked_async = 1'b0;
        tick(2);
        clr_cnt = 1'b1;
        tick(1);
        clr_cnt = 1'b0;
        locked_async = 1'b1;
        chk("clr_relock", relock_cnt, 8'd0);
        chk("clr_ready", {7'd0, ready}, 8'd0);
        tick(15);
        chk("clr_ready_back", {7'd0, ready}, 8'd1);

        lose_lock();
        tick(13);
        chk("hold_relock", relock_cnt, 8'd1);
        chk("hold_pll_rst", {7'd0, pll_rst}, 8'd0);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_pll_rst", {7'd0, pll_rst}, 8'd1);
        chk("async_sys_rst_n", {7'd0, sys_rst_n}, 8'd0);
        chk("async_ready", {7'd0, ready}, 8'd0);
        chk("async_relock", relock_cnt, 8'd0);
        tick(1);
        rstn = 1'b1;
        tick(16);
        chk("restart_ready_e16", {7'd0, ready}, 8'd0);
        tick(1);
        chk("restart_ready_e17", {7'd0, ready}, 8'd1);

        locked_async = 1'b1;
        do_reset();
        tick(8);
        locked_async = 1'b0;
        tick(1);
        locked_async = 1'b1;
        tick(8);
        chk("glitch_ready_e17", {7'd0, ready}, 8'd0);
        tick(6);
        chk("glitch_ready_e23", {7'd0, ready}, 8'd0);
        tick(1);
        chk("glitch_ready_e24", {7'd0, ready}, 8'd1);

        locked_async = 1'b0;
        do_reset();
        tick(4);
        chk("to_pll_rst_e4", {7'd0, pll_rst}, 8'd0);
        tick(31);
        chk("to_pll_rst_e35", {7'd0, pll_rst}, 8'd0);
        tick(1);
        chk("to_pll_rst_e36", {7'd0, pll_rst}, 8'd1);
        tick(3);
        chk("to_pll_rst_e39", {7'd0, pll_rst}, 8'd1);
        tick(1);
        chk("to_pll_rst_e40", {7'd0, pll_rst}, 8'd0);
        tick(31);
        chk("to_pll_rst_e71", {7'd0, pll_rst}, 8'd0);
        tick(1);
        chk("to_pll_rst_e72", {7'd0, pll_rst}, 8'd1);
        chk("to_ready", {7'd0, ready}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
